// File: rtl/gate_cout_sequencer.sv
// Timed counting gate for NCH counters; latches carry-out pulses and serialises them round-robin.
// cout->ev_valid latency 2 cycles; ev_chan/ev_valid held while ev_ready is low, overflow sets lost.
module gate_cout_sequencer #(
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int WIN_W = 16,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] gate_len,
  output logic             enable,
  input  logic [NCH-1:0]   cout_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CHW-1:0]   ev_chan,
  output logic [NCH-1:0]   lost,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GATE  = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   lost_q, lost_d;
  logic [CHW-1:0]   last_q, last_d;
  logic [CHW-1:0]   ev_chan_q, ev_chan_d;
  logic             ev_valid_q, ev_valid_d;
  logic             enable_q, busy_q, done_q;

  logic             slot_free;
  logic             gnt_found;
  logic [CHW-1:0]   gnt_idx;
  logic [CHW-1:0]   cand;
  logic [NCH-1:0]   gnt_vec;
  logic [NCH-1:0]   hit;
  logic             capture;

  assign slot_free = !ev_valid_q || ev_ready;
  assign capture   = (state_q == S_GATE) || (state_q == S_GUARD) || (state_q == S_DRAIN);
  assign hit       = capture ? cout_in : '0;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CHW'((int'(last_q) + k) % NCH);
      if (!gnt_found && pending_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_vec = (slot_free && gnt_found) ? (NCH'(1) << gnt_idx) : '0;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = (pending_q & ~gnt_vec) | hit;
    lost_d     = lost_q | (hit & pending_q & ~gnt_vec);
    ev_valid_d = ev_valid_q;
    ev_chan_d  = ev_chan_q;
    last_d     = last_q;

    if (slot_free) begin
      ev_valid_d = gnt_found;
      if (gnt_found) begin
        ev_chan_d = gnt_idx;
        last_d    = gnt_idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && (gate_len != '0)) begin
          state_d = S_GATE;
          timer_d = gate_len;
          lost_d  = '0;
        end
      end
      S_GATE: begin
        if (timer_q == WIN_W'(1)) begin
          state_d = S_GUARD;
          timer_d = WIN_W'(GUARD);
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      S_GUARD: begin
        if (timer_q == WIN_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          timer_d = timer_q - WIN_W'(1);
        end
      end
      S_DRAIN: begin
        if ((pending_q == '0) && slot_free) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything but keeps the lost history for inspection.
    if (abort) begin
      state_d    = S_IDLE;
      pending_d  = '0;
      ev_valid_d = 1'b0;
      lost_d     = lost_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      lost_q     <= '0;
      last_q     <= CHW'(NCH - 1);
      ev_chan_q  <= '0;
      ev_valid_q <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      lost_q     <= lost_d;
      last_q     <= last_d;
      ev_chan_q  <= ev_chan_d;
      ev_valid_q <= ev_valid_d;
      enable_q   <= (state_d == S_GATE);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign enable   = enable_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ev_valid = ev_valid_q;
  assign ev_chan  = ev_chan_q;
  assign lost     = lost_q;

endmodule
